// File: rtl/cache_arbiter_pkg.sv
// Shared types for the cache arbiter: FSM state encoding and grant source.
// Optional round-robin grant policy is selected with the ARB_RR_EN macro.
package cache_types;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'b00,
        ARB_ICACHE = 2'b01,
        ARB_DCACHE = 2'b10
    } arb_state_t;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } arb_src_t;

    function automatic arb_src_t other_src(input arb_src_t s);
        return (s == SRC_I) ? SRC_D : SRC_I;
    endfunction

endpackage

// File: rtl/cache_arbiter_prio_sel.sv
// Combinational grant picker for the cache arbiter. Fixed D-over-I priority by
// default; with ARB_RR_EN a simultaneous request goes to the side not granted last.
module arb_prio_sel
    import cache_types::*;
(
    input  logic     i_req,
    input  logic     d_req,
    input  arb_src_t last_src,
    output logic     grant_valid,
    output arb_src_t grant_src
);

    always_comb begin
        grant_valid = i_req | d_req;
        grant_src   = d_req ? SRC_D : SRC_I;
`ifdef ARB_RR_EN
        if (i_req && d_req) begin
            grant_src = other_src(last_src);
        end
`endif
    end

`ifndef ARB_RR_EN
    logic unused_last_src;
    assign unused_last_src = ^last_src;
`endif

endmodule

// File: rtl/cache_arbiter.sv
// Serializes I-cache and D-cache line misses onto one memory port, one line at a time.
// Define ARB_RR_EN for alternating grants on simultaneous requests (default: D over I).
module cache_arbiter
    import cache_types::*;
#(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam int OFF_W = $clog2(LINE_W / 8);

    arb_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              pmem_read_q, pmem_read_d;
    logic              pmem_write_q, pmem_write_d;
    arb_src_t          last_src;
    logic              grant_valid;
    arb_src_t          grant_src;

`ifdef ARB_RR_EN
    arb_src_t last_src_q, last_src_d;
    assign last_src = last_src_q;
`else
    assign last_src = SRC_I;
`endif

    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    endfunction

    arb_prio_sel u_prio_sel (
        .i_req      (i_read),
        .d_req      (d_read | d_write),
        .last_src   (last_src),
        .grant_valid(grant_valid),
        .grant_src  (grant_src)
    );

    // Request registers are zeroed on completion so pmem_* read as 0 while idle.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        pmem_read_d  = pmem_read_q;
        pmem_write_d = pmem_write_q;
`ifdef ARB_RR_EN
        last_src_d   = last_src_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (grant_valid) begin
`ifdef ARB_RR_EN
                    last_src_d = grant_src;
`endif
                    if (grant_src == SRC_D) begin
                        state_d      = ARB_DCACHE;
                        addr_d       = line_align(d_address);
                        wdata_d      = d_wdata;
                        pmem_write_d = d_write;
                        pmem_read_d  = ~d_write;
                    end else begin
                        state_d      = ARB_ICACHE;
                        addr_d       = line_align(i_address);
                        wdata_d      = '0;
                        pmem_write_d = 1'b0;
                        pmem_read_d  = 1'b1;
                    end
                end
            end
            ARB_ICACHE, ARB_DCACHE: begin
                if (pmem_resp) begin
                    state_d      = ARB_IDLE;
                    addr_d       = '0;
                    wdata_d      = '0;
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                end
            end
            default: begin
                state_d      = ARB_IDLE;
                addr_d       = '0;
                wdata_d      = '0;
                pmem_read_d  = 1'b0;
                pmem_write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ARB_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
`ifdef ARB_RR_EN
            last_src_q   <= SRC_I;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            pmem_read_q  <= pmem_read_d;
            pmem_write_q <= pmem_write_d;
`ifdef ARB_RR_EN
            last_src_q   <= last_src_d;
`endif
        end
    end

    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    // Responses pass straight through to the side that owns the grant.
    assign i_resp  = (state_q == ARB_ICACHE) && pmem_resp;
    assign d_resp  = (state_q == ARB_DCACHE) && pmem_resp;
    assign i_rdata = i_resp ? pmem_rdata : '0;
    assign d_rdata = (d_resp && pmem_read_q) ? pmem_rdata : '0;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!(d_read && d_write));
        end
    end
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios plus randomized
// transactions scored against a transaction-level grant-order model.
module tb_cache_arbiter;
    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    logic              clk;
    logic              rst;
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    cache_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    // ---- clock / reset ----
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_cmp  = 0;
    int n_fail = 0;
    logic model_last_d;                  // 1 = D-cache was granted last
    logic [ADDR_W+1:0] exp_q[$];         // {is_write, is_d, line_address}

    function automatic logic [ADDR_W-1:0] line_of(input logic [ADDR_W-1:0] a);
        return a - (a % (LINE_W / 8));
    endfunction

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] v;
        for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic policy_first_d(input logic last_d);
`ifdef ARB_RR_EN
        return !last_d;
`else
        return 1'b1;
`endif
    endfunction

    // ---- driver tasks ----
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        i_read = 0; i_address = '0; d_read = 0; d_write = 0;
        d_address = '0; d_wdata = '0; pmem_rdata = '0; pmem_resp = 0;
    endtask

    // Leaves the caller at a negedge with a grant visible, or reports a timeout.
    task automatic wait_grant(output bit got);
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            sample();
            got = pmem_read | pmem_write;
        end
    endtask

    // ---- scenarios ----
    task automatic test_reset();
        clear_inputs();
        rst = 0;
        tick(); tick();
        sample();
        n_cmp++; if (pmem_read !== 1'b0) begin n_fail++; $display("FAIL reset_pmem_read: got %b want 0", pmem_read); end
        n_cmp++; if (pmem_write !== 1'b0) begin n_fail++; $display("FAIL reset_pmem_write: got %b want 0", pmem_write); end
        n_cmp++; if (pmem_address !== '0) begin n_fail++; $display("FAIL reset_pmem_address: got %h want 0", pmem_address); end
        n_cmp++; if (pmem_wdata !== '0) begin n_fail++; $display("FAIL reset_pmem_wdata: got %h want 0", pmem_wdata); end
        n_cmp++; if ({i_resp, d_resp} !== 2'b00) begin n_fail++; $display("FAIL reset_resp: got %b want 00", {i_resp, d_resp}); end
        tick();
        rst = 1;
        model_last_d = 0;
    endtask

    task automatic test_i_only();
        logic [LINE_W-1:0] pat;
        pat = rand_line();
        tick();
        i_read = 1; i_address = 32'h0000_1234;
        sample();
        n_cmp++; if (pmem_read !== 1'b0) begin n_fail++; $display("FAIL ionly_pre_grant: got %b want 0", pmem_read); end
        tick(); sample();
        n_cmp++; if (pmem_read !== 1'b1) begin n_fail++; $display("FAIL ionly_pmem_read: got %b want 1", pmem_read); end
        n_cmp++; if (pmem_address !== 32'h0000_1220) begin n_fail++; $display("FAIL ionly_address: got %h want 00001220", pmem_address); end
        repeat (4) begin
            tick(); sample();
            n_cmp++; if ({pmem_read, i_resp, d_resp} !== 3'b100) begin n_fail++; $display("FAIL ionly_wait: got %b want 100", {pmem_read, i_resp, d_resp}); end
        end
        tick();
        pmem_resp = 1; pmem_rdata = pat;
        sample();
        n_cmp++; if (i_resp !== 1'b1) begin n_fail++; $display("FAIL ionly_i_resp: got %b want 1", i_resp); end
        n_cmp++; if (i_rdata !== pat) begin n_fail++; $display("FAIL ionly_i_rdata: got %h want %h", i_rdata, pat); end
        n_cmp++; if ({d_resp, d_rdata} !== '0) begin n_fail++; $display("FAIL ionly_d_quiet: got %b want 0", d_resp); end
        tick();
        pmem_resp = 0; i_read = 0;
        sample();
        n_cmp++; if ({pmem_read, pmem_write, i_resp, i_rdata} !== '0) begin n_fail++; $display("FAIL ionly_idle: got %b want 0", pmem_read); end
        model_last_d = 0;
    endtask

    task automatic test_d_write();
        logic [LINE_W-1:0] wpat;
        wpat = {(LINE_W/8){8'hA5}};
        tick();
        d_write = 1; d_address = 32'h8000_0040; d_wdata = wpat;
        tick(); sample();
        n_cmp++; if ({pmem_write, pmem_read} !== 2'b10) begin n_fail++; $display("FAIL dwr_op: got %b want 10", {pmem_write, pmem_read}); end
        n_cmp++; if (pmem_address !== 32'h8000_0040) begin n_fail++; $display("FAIL dwr_address: got %h want 80000040", pmem_address); end
        n_cmp++; if (pmem_wdata !== wpat) begin n_fail++; $display("FAIL dwr_wdata: got %h want %h", pmem_wdata, wpat); end
        tick(); d_wdata = '0;
        sample();
        n_cmp++; if (pmem_wdata !== wpat) begin n_fail++; $display("FAIL dwr_wdata_held: got %h want %h", pmem_wdata, wpat); end
        tick();
        pmem_resp = 1; pmem_rdata = rand_line();
        sample();
        n_cmp++; if ({d_resp, i_resp} !== 2'b10) begin n_fail++; $display("FAIL dwr_resp: got %b want 10", {d_resp, i_resp}); end
        n_cmp++; if (d_rdata !== '0) begin n_fail++; $display("FAIL dwr_d_rdata: got %h want 0", d_rdata); end
        tick();
        pmem_resp = 0; d_write = 0;
        sample();
        n_cmp++; if ({pmem_read, pmem_write, pmem_address} !== '0) begin n_fail++; $display("FAIL dwr_idle: got %b%b want 00", pmem_read, pmem_write); end
        model_last_d = 1;
    endtask

    task automatic test_simultaneous();
        logic [LINE_W-1:0] pd, pi;
        pd = rand_line(); pi = rand_line();
        tick();
        i_read = 1; i_address = 32'h0000_2004; d_read = 1; d_address = 32'h0000_3018;
        tick(); sample();
        n_cmp++; if (pmem_address !== 32'h0000_3000) begin n_fail++; $display("FAIL sim_first_d: got %h want 00003000", pmem_address); end
        tick();
        pmem_resp = 1; pmem_rdata = pd;
        sample();
        n_cmp++; if ({d_resp, i_resp} !== 2'b10) begin n_fail++; $display("FAIL sim_d_resp: got %b want 10", {d_resp, i_resp}); end
        n_cmp++; if (d_rdata !== pd) begin n_fail++; $display("FAIL sim_d_rdata: got %h want %h", d_rdata, pd); end
        n_cmp++; if (i_rdata !== '0) begin n_fail++; $display("FAIL sim_i_rdata_quiet: got %h want 0", i_rdata); end
        tick();
        pmem_resp = 0; d_read = 0;
        sample();
        n_cmp++; if ({pmem_read, pmem_write} !== 2'b00) begin n_fail++; $display("FAIL sim_idle_gap: got %b want 00", {pmem_read, pmem_write}); end
        tick(); sample();
        n_cmp++; if ({pmem_read, pmem_address} !== {1'b1, 32'h0000_2000}) begin n_fail++; $display("FAIL sim_second_i: got %b %h want 1 00002000", pmem_read, pmem_address); end
        tick();
        pmem_resp = 1; pmem_rdata = pi;
        sample();
        n_cmp++; if ({i_resp, d_resp} !== 2'b10) begin n_fail++; $display("FAIL sim_i_resp: got %b want 10", {i_resp, d_resp}); end
        n_cmp++; if (i_rdata !== pi) begin n_fail++; $display("FAIL sim_i_rdata: got %h want %h", i_rdata, pi); end
        tick();
        pmem_resp = 0; i_read = 0;
        model_last_d = 0;
    endtask

    task automatic test_grant_order();
        logic exp_d;
        bit got;
        tick();
        i_read = 1; i_address = 32'h0001_0000; d_read = 1; d_address = 32'h0002_0000;
        for (int t = 0; t < 4; t++) begin
            exp_d = policy_first_d(model_last_d);
            wait_grant(got);
            n_cmp++;
            if (!got) begin
                n_fail++; $display("FAIL order_timeout: got no grant want grant %0d", t);
                break;
            end
            if ((pmem_address == 32'h0002_0000) !== exp_d) begin n_fail++; $display("FAIL order_grant%0d: got addr %h want d=%b", t, pmem_address, exp_d); end
            tick();
            pmem_resp = 1; pmem_rdata = rand_line();
            tick();
            pmem_resp = 0;
            if (t == 3) begin i_read = 0; d_read = 0; end
            model_last_d = exp_d;
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [LINE_W-1:0] pi;
        pi = rand_line();
        tick();
        d_read = 1; d_address = 32'h0000_5555;
        tick(); sample();
        n_cmp++; if (pmem_read !== 1'b1) begin n_fail++; $display("FAIL rmid_granted: got %b want 1", pmem_read); end
        tick();
        rst = 0;
        tick();
        rst = 1; d_read = 0; pmem_resp = 1; pmem_rdata = rand_line();
        sample();
        n_cmp++; if ({pmem_read, pmem_write, pmem_address, pmem_wdata} !== '0) begin n_fail++; $display("FAIL rmid_pmem_zero: got %b%b %h want 00 0", pmem_read, pmem_write, pmem_address); end
        n_cmp++; if ({d_resp, i_resp, d_rdata, i_rdata} !== '0) begin n_fail++; $display("FAIL rmid_resp_dropped: got %b%b want 00", d_resp, i_resp); end
        tick();
        pmem_resp = 0; i_read = 1; i_address = 32'h0000_40CC;
        sample();
        n_cmp++; if (d_resp !== 1'b0) begin n_fail++; $display("FAIL rmid_no_d_resp: got %b want 0", d_resp); end
        tick(); sample();
        n_cmp++; if ({pmem_read, pmem_address} !== {1'b1, 32'h0000_40C0}) begin n_fail++; $display("FAIL rmid_regrant: got %b %h want 1 000040c0", pmem_read, pmem_address); end
        tick();
        pmem_resp = 1; pmem_rdata = pi;
        sample();
        n_cmp++; if ({i_resp, i_rdata} !== {1'b1, pi}) begin n_fail++; $display("FAIL rmid_i_resp: got %b %h want 1 %h", i_resp, i_rdata, pi); end
        tick();
        pmem_resp = 0; i_read = 0;
        model_last_d = 0;
    endtask

    task automatic test_random();
        logic [ADDR_W+1:0] e_i, e_d, e;
        logic [LINE_W-1:0] wd, rd;
        int kind;
        logic dw, first_d;
        bit got;
        repeat (24) begin
            kind = $urandom_range(0, 2);
            dw = 1'($urandom_range(0, 1));
            wd = rand_line();
            tick();
            i_address = $urandom; d_address = $urandom; d_wdata = wd;
            e_i = {1'b0, 1'b0, line_of(i_address)};
            e_d = {dw, 1'b1, line_of(d_address)};
            if (kind == 0) exp_q.push_back(e_i);
            else if (kind == 1) exp_q.push_back(e_d);
            else begin
                first_d = policy_first_d(model_last_d);
                exp_q.push_back(first_d ? e_d : e_i);
                exp_q.push_back(first_d ? e_i : e_d);
            end
            i_read = (kind != 1);
            d_read = (kind != 0) && !dw;
            d_write = (kind != 0) && dw;
            while (exp_q.size() > 0) begin
                wait_grant(got);
                n_cmp++;
                if (!got) begin
                    n_fail++; $display("FAIL rnd_timeout: got no grant want %h", exp_q[0]);
                    exp_q.delete();
                    break;
                end
                e = exp_q.pop_front();
                if ({pmem_write, e[ADDR_W], pmem_address} !== e || pmem_read !== !e[ADDR_W+1]) begin
                    n_fail++; $display("FAIL rnd_grant: got w=%b r=%b addr=%h want %h", pmem_write, pmem_read, pmem_address, e);
                end
                if (e[ADDR_W+1]) begin
                    n_cmp++; if (pmem_wdata !== wd) begin n_fail++; $display("FAIL rnd_wdata: got %h want %h", pmem_wdata, wd); end
                end
                repeat ($urandom_range(1, 4)) tick();
                rd = rand_line();
                pmem_resp = 1; pmem_rdata = rd;
                sample();
                n_cmp++;
                if (e[ADDR_W]) begin
                    if ({d_resp, i_resp, i_rdata} !== {2'b10, {LINE_W{1'b0}}} || d_rdata !== (e[ADDR_W+1] ? '0 : rd)) begin
                        n_fail++; $display("FAIL rnd_d_resp: got %b%b %h want 10 read=%b", d_resp, i_resp, d_rdata, !e[ADDR_W+1]);
                    end
                end else begin
                    if ({i_resp, d_resp, d_rdata} !== {2'b10, {LINE_W{1'b0}}} || i_rdata !== rd) begin
                        n_fail++; $display("FAIL rnd_i_resp: got %b%b %h want 10 %h", i_resp, d_resp, i_rdata, rd);
                    end
                end
                tick();
                pmem_resp = 0;
                if (e[ADDR_W]) begin d_read = 0; d_write = 0; end
                else i_read = 0;
                model_last_d = e[ADDR_W];
            end
            sample();
            n_cmp++; if ({pmem_read, pmem_write} !== 2'b00) begin n_fail++; $display("FAIL rnd_idle: got %b want 00", {pmem_read, pmem_write}); end
        end
    endtask

    // ---- sequence and report ----
    initial begin
        clear_inputs();
        rst = 0;
        model_last_d = 0;
        test_reset();
        test_i_only();
        test_d_write();
        test_simultaneous();
        test_grant_order();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Arbitrates cache-line miss traffic from the split L1 instruction cache and L1 data cache onto the single shared physical-memory (LLC/burst adapter) port. It sits directly downstream of both L1 caches and upstream of the memory port. It serializes one line transaction at a time and returns the response only to the granted requester. It holds each grant until the memory side responds, so both caches see a plain request/response handshake identical to a private memory port.

## Interface
Parameters:
- LINE_W, 256, cache line width in bits
- ADDR_W, 32, address width; low log2(LINE_W/8) bits are line offset

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset (asserted when 0)
- i_read  in  1  I-cache line read request, held until i_resp
- i_address  in  ADDR_W  I-cache request address
- i_rdata  out  LINE_W  line returned to I-cache
- i_resp  out  1  one-cycle completion pulse to I-cache
- d_read  in  1  D-cache line read (fill) request
- d_write  in  1  D-cache line write (writeback) request
- d_address  in  ADDR_W  D-cache request address
- d_wdata  in  LINE_W  D-cache writeback line
- d_rdata  out  LINE_W  line returned to D-cache
- d_resp  out  1  one-cycle completion pulse to D-cache
- pmem_read  out  1  memory-side read request
- pmem_write  out  1  memory-side write request
- pmem_address  out  ADDR_W  line-aligned memory address
- pmem_wdata  out  LINE_W  memory-side write line
- pmem_rdata  in  LINE_W  memory-side read line
- pmem_resp  in  1  memory-side completion, valid for one cycle

## Operation
- States: ARB_IDLE, ARB_ICACHE, ARB_DCACHE.
- ARB_IDLE: all pmem_* and *_resp outputs are 0. The block samples the requests each cycle.
  - D request pending (d_read|d_write): go to ARB_DCACHE.
  - Else i_read: go to ARB_ICACHE.
  - Default priority is fixed, D over I. The D-side miss belongs to an older instruction.
- On the grant edge, the block latches the granted address (offset bits zeroed), the op (read/write) and d_wdata into request registers. pmem_* outputs drive from these registers only, never from live inputs.
- ARB_ICACHE: pmem_read=1. On pmem_resp, i_resp=1 and i_rdata=pmem_rdata in the same cycle, then go to ARB_IDLE.
- ARB_DCACHE: pmem_read or pmem_write=1 per the latched op. On pmem_resp, d_resp=1 in the same cycle, plus d_rdata=pmem_rdata for reads, then go to ARB_IDLE.
- d_read and d_write both high is illegal. Write wins, and a simulation assertion fires.
- A non-granted requester waits with no response. Its request stays pending and is re-evaluated in ARB_IDLE.
- pmem_resp in ARB_IDLE is ignored.
- i_rdata and d_rdata are 0 whenever the matching resp is 0.

## Timing
- Reset (rst=0 at an edge): state becomes ARB_IDLE and the request registers clear. All outputs are 0 the following cycle, including mid-transaction. A memory response in flight at reset is dropped.
- Grant latency: a request seen in ARB_IDLE in cycle N puts pmem_read/pmem_write high in cycle N+1.
- Response latency: the resp pulse appears in the same cycle as pmem_resp (combinational pass-through).
- After every response the block spends one cycle in ARB_IDLE. Back-to-back transactions are therefore separated by at least one idle cycle, which gives the cache a cycle to drop its request.
- Simultaneous I and D requests in ARB_IDLE: D is granted. I is granted in the ARB_IDLE cycle following D's response, if i_read is still high.
- A D writeback followed by a D fill (evict then refill) is two separate grants. An I request pending at that point may be granted between them only under ARB_RR_EN.

## Configuration
- ARB_RR_EN defined: the block keeps a 1-bit last-granted register.
  - On a simultaneous I/D request in ARB_IDLE, it grants the side not granted last.
  - The register resets to "I last", so D is first.
  - Single-requester behaviour is unchanged.
- ARB_RR_EN undefined: fixed D-over-I priority and no last-granted register.

## Structure
- cache_types package gains:
  - arb_state_t enum: ARB_IDLE=2'b00, ARB_ICACHE=2'b01, ARB_DCACHE=2'b10.
  - arb_src_t enum: SRC_I=1'b0, SRC_D=1'b1, used for the last-granted register and grant select.
- One sub-module, arb_prio_sel: a combinational grant picker. Inputs are i_req, d_req and last_src; outputs are grant_valid and grant_src. It is the only place the ARB_RR_EN policy differs.
- The top level holds the FSM, request registers and response steering.

## Test plan
- I only: i_read=1, i_address=0x0000_1234, memory responds 5 cycles after pmem_read. Expected: pmem_address=0x0000_1220 and pmem_read high from cycle 1. i_resp pulses in the pmem_resp cycle with i_rdata equal to the 256-bit pattern. d_resp stays 0.
- D writeback: d_write=1, d_address=0x8000_0040, d_wdata=0xA5 pattern. Expected: pmem_write=1, pmem_wdata=0xA5 pattern, d_resp pulses with pmem_resp, then the block returns to ARB_IDLE.
- Simultaneous I/D read in the same cycle. Expected: D is served first. One idle cycle follows, then I is served. Each resp goes to the correct side only.
- ARB_RR_EN, both requesters re-requesting continuously for 4 transactions. Expected grant order D, I, D, I. Without the macro, the order is D, D, D, D while d_read stays high.
- Reset mid-transaction: rst=0 while in ARB_DCACHE, and pmem_resp arrives one cycle later. Expected: all outputs are 0 the cycle after reset, d_resp is never asserted, and a new i_read is granted normally once rst returns to 1.
